// File: rtl/boa_pmu_pkg.sv
// Shared types for the PMU sequencer: FSM state encoding, reset-cause
// encoding, and a small constant helper used to size the phase counter.
package boa_pmu_pkg;

    typedef enum logic [2:0] {
        PMU_RESET = 3'd0,
        PMU_RUN   = 3'd1,
        PMU_DRAIN = 3'd2,
        PMU_OFF   = 3'd3,
        PMU_WAKE  = 3'd4
    } pmu_state_t;

    typedef enum logic [1:0] {
        CAUSE_POR  = 2'd0,
        CAUSE_SOFT = 2'd1,
        CAUSE_WAKE = 2'd2
    } pmu_cause_t;

    // Largest of three phase lengths; the shared counter must hold any of them.
    function automatic int unsigned pmu_max3(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/boa_pmu_sequencer_if.sv
// pmu_bus: level requests from the CPU to the PMU. The CPU drives rst/shdn,
// the PMU sequencer only observes them.
interface pmu_bus;
    logic rst;
    logic shdn;

    modport CPU (output rst, output shdn);
    modport PMU (input  rst, input  shdn);
endinterface

// File: rtl/boa_sync2.sv
// Two-flop synchroniser with asynchronous active-low clear, used to bring
// the asynchronous wake request into the always-on clock domain.
module boa_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture; the first stage may go metastable, the second resolves it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/boa_pmu_sequencer.sv
// PMU-side sequencer: stretches power-on reset, services soft-reset and
// shutdown requests from the CPU, drains traffic before power-off, and
// restores power plus a full reset episode on wake. Records the cause of
// the last reset and whether the last drain timed out.
module boa_pmu_sequencer
    import boa_pmu_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 32'd16,
    parameter int unsigned DRAIN_TIMEOUT = 32'd256,
    parameter int unsigned PWR_SETTLE    = 32'd64
) (
    input  logic       clk,
    input  logic       rst,
    pmu_bus.PMU        pmb,
    input  logic       wake,
    input  logic       quiesce_ack,
    output logic       sys_rst,
    output logic       pwr_en,
    output logic       quiesce_req,
    output logic [1:0] cause,
    output logic       drain_to,
    output logic [2:0] state_o
);

    localparam int CNT_W = $clog2(pmu_max3(RST_CYCLES, DRAIN_TIMEOUT, PWR_SETTLE)) + 1;

    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] WAKE_LOAD  = CNT_W'(PWR_SETTLE - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    pmu_state_t       state_r,   state_nxt_s;
    logic [CNT_W-1:0] cnt_r,     cnt_nxt_s;
    pmu_cause_t       cause_r,   cause_nxt_s;
    logic             drain_to_r, drain_to_nxt_s;
    logic             sys_rst_r, sys_rst_nxt_s;
    logic             pwr_en_r,  pwr_en_nxt_s;
    logic             quiesce_r, quiesce_nxt_s;
    logic             wake_s;
    logic             cnt_zero_s;
    logic [CNT_W-1:0] cnt_dec_s;

    boa_sync2 u_wake_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (wake),
        .q     (wake_s)
    );

    assign cnt_zero_s = (cnt_r == CNT_ZERO);
    assign cnt_dec_s  = cnt_r - CNT_ONE;

    // Next-state, counter and status-record logic for the sequencing FSM.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        cause_nxt_s    = cause_r;
        drain_to_nxt_s = drain_to_r;
        case (state_r)
            PMU_RESET: begin
                // Requests and wake are deliberately ignored while reset is held.
                if (cnt_zero_s) begin
                    state_nxt_s = PMU_RUN;
                end else begin
                    cnt_nxt_s = cnt_dec_s;
                end
            end
            PMU_RUN: begin
                // Shutdown outranks soft reset when both arrive together.
                if (pmb.shdn) begin
                    state_nxt_s = PMU_DRAIN;
                    cnt_nxt_s   = DRAIN_LOAD;
                end else if (pmb.rst) begin
                    state_nxt_s = PMU_RESET;
                    cnt_nxt_s   = RST_LOAD;
                    cause_nxt_s = CAUSE_SOFT;
                end else begin
                    state_nxt_s = PMU_RUN;
                end
            end
            PMU_DRAIN: begin
                // Once committed, shutdown completes; an ack on the expiry cycle still counts.
                if (quiesce_ack) begin
                    state_nxt_s    = PMU_OFF;
                    drain_to_nxt_s = 1'b0;
                end else if (cnt_zero_s) begin
                    state_nxt_s    = PMU_OFF;
                    drain_to_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_dec_s;
                end
            end
            PMU_OFF: begin
                if (wake_s) begin
                    state_nxt_s = PMU_WAKE;
                    cnt_nxt_s   = WAKE_LOAD;
                end else begin
                    state_nxt_s = PMU_OFF;
                end
            end
            PMU_WAKE: begin
                if (cnt_zero_s) begin
                    state_nxt_s = PMU_RESET;
                    cnt_nxt_s   = RST_LOAD;
                    cause_nxt_s = CAUSE_WAKE;
                end else begin
                    cnt_nxt_s = cnt_dec_s;
                end
            end
            default: begin
                state_nxt_s = PMU_RESET;
                cnt_nxt_s   = RST_LOAD;
            end
        endcase
    end

    // Output decode from the next state so outputs switch on the same edge as the state.
    always_comb begin
        sys_rst_nxt_s = 1'b1;
        pwr_en_nxt_s  = 1'b1;
        quiesce_nxt_s = 1'b0;
        case (state_nxt_s)
            PMU_RESET: begin
                sys_rst_nxt_s = 1'b1;
            end
            PMU_RUN: begin
                sys_rst_nxt_s = 1'b0;
            end
            PMU_DRAIN: begin
                sys_rst_nxt_s = 1'b0;
                quiesce_nxt_s = 1'b1;
            end
            PMU_OFF: begin
                // Keep the system in reset whenever its power is removed.
                pwr_en_nxt_s = 1'b0;
            end
            PMU_WAKE: begin
                sys_rst_nxt_s = 1'b1;
            end
            default: begin
                sys_rst_nxt_s = 1'b1;
            end
        endcase
    end

    // State, counter, status and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= PMU_RESET;
            cnt_r      <= RST_LOAD;
            cause_r    <= CAUSE_POR;
            drain_to_r <= 1'b0;
            sys_rst_r  <= 1'b1;
            pwr_en_r   <= 1'b1;
            quiesce_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            cause_r    <= cause_nxt_s;
            drain_to_r <= drain_to_nxt_s;
            sys_rst_r  <= sys_rst_nxt_s;
            pwr_en_r   <= pwr_en_nxt_s;
            quiesce_r  <= quiesce_nxt_s;
        end
    end

    assign sys_rst     = sys_rst_r;
    assign pwr_en      = pwr_en_r;
    assign quiesce_req = quiesce_r;
    assign cause       = cause_r;
    assign drain_to    = drain_to_r;
    assign state_o     = state_r;

endmodule

// File: tb/tb_boa_pmu_sequencer.sv
// Randomised scoreboard bench for boa_pmu_sequencer. A driver picks inputs
// each cycle, advances a phase/elapsed-cycle reference model and queues the
// expected outputs; a monitor compares the DUT against the queue.
module tb_boa_pmu_sequencer;

    localparam int RC = 16;
    localparam int DT = 256;
    localparam int PS = 64;

    localparam int PH_RESET = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_DRAIN = 2;
    localparam int PH_OFF   = 3;
    localparam int PH_WAKE  = 4;

    logic       clk;
    logic       rstn;
    logic       wake;
    logic       quiesce_ack;
    logic       sys_rst;
    logic       pwr_en;
    logic       quiesce_req;
    logic [1:0] cause;
    logic       drain_to;
    logic [2:0] state_o;

    pmu_bus pmb_if ();

    boa_pmu_sequencer #(
        .RST_CYCLES    (RC),
        .DRAIN_TIMEOUT (DT),
        .PWR_SETTLE    (PS)
    ) dut (
        .clk         (clk),
        .rst         (rstn),
        .pmb         (pmb_if),
        .wake        (wake),
        .quiesce_ack (quiesce_ack),
        .sys_rst     (sys_rst),
        .pwr_en      (pwr_en),
        .quiesce_req (quiesce_req),
        .cause       (cause),
        .drain_to    (drain_to),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {sys_rst, pwr_en, quiesce_req, cause, drain_to, state}
    logic [8:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    // Reference model: current phase, cycles already spent in it, records.
    int m_phase = PH_RESET;
    int m_spent = 0;
    int m_cause = 0;
    int m_dt    = 0;
    bit wake_hist[$];   // wake as sampled at each past edge, newest last

    // Drain plan chosen when shutdown is requested
    int ack_at = -1;
    int rst_at = -1;
    bit wake_lvl = 1'b0;

    function automatic logic [8:0] expected_outputs();
        logic sr, pe, qr;
        logic [1:0] cs;
        logic [2:0] st;
        sr = (m_phase == PH_RESET) || (m_phase == PH_OFF) || (m_phase == PH_WAKE);
        pe = (m_phase != PH_OFF);
        qr = (m_phase == PH_DRAIN);
        cs = 2'(m_cause);
        st = 3'(m_phase);
        return {sr, pe, qr, cs, 1'(m_dt), st};
    endfunction

    task automatic enter(input int ph);
        m_phase = ph;
        m_spent = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, then predict the
    // outputs that will hold after the next rising edge.
    task automatic tick(input bit i_rst, input bit i_shdn, input bit i_ack,
                        input bit i_wake, input bit i_rstn);
        bit ws;
        @(negedge clk);
        #1;
        rstn        = i_rstn;
        pmb_if.rst  = i_rst;
        pmb_if.shdn = i_shdn;
        quiesce_ack = i_ack;
        wake        = i_wake;
        if (!i_rstn) begin
            enter(PH_RESET);
            m_cause = 0;
            m_dt    = 0;
            wake_hist.delete();
        end else begin
            // wake is visible to the FSM two edges after it is sampled
            ws = (wake_hist.size() >= 2) ? wake_hist[wake_hist.size()-2] : 1'b0;
            wake_hist.push_back(i_wake);
            if (wake_hist.size() > 4) void'(wake_hist.pop_front());
            case (m_phase)
                PH_RESET: if (m_spent + 1 >= RC) enter(PH_RUN); else m_spent++;
                PH_RUN: begin
                    if (i_shdn) enter(PH_DRAIN);
                    else if (i_rst) begin enter(PH_RESET); m_cause = 1; end
                end
                PH_DRAIN: begin
                    if (i_ack) begin enter(PH_OFF); m_dt = 0; end
                    else if (m_spent + 1 >= DT) begin enter(PH_OFF); m_dt = 1; end
                    else m_spent++;
                end
                PH_OFF: if (ws) enter(PH_WAKE);
                PH_WAKE: begin
                    if (m_spent + 1 >= PS) begin enter(PH_RESET); m_cause = 2; end
                    else m_spent++;
                end
                default: enter(PH_RESET);
            endcase
        end
        exp_q.push_back(expected_outputs());
    endtask

    // Monitor: every cycle the DUT presents a full output set; compare it.
    always @(negedge clk) begin
        logic [8:0] e;
        logic [8:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {sys_rst, pwr_en, quiesce_req, cause, drain_to, state_o};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL outputs t=%0t {sys_rst,pwr_en,qreq,cause,drain_to,state} got=%b expected=%b",
                         $time, a, e);
            end
        end
    end

    initial begin
        bit r, sh, ack, rn;
        int k;
        rstn        = 1'b0;
        pmb_if.rst  = 1'b0;
        pmb_if.shdn = 1'b0;
        quiesce_ack = 1'b0;
        wake        = 1'b0;

        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int c = 0; c < 9000; c++) begin
            r = 1'b0; sh = 1'b0; ack = 1'b0; rn = 1'b1;
            case (m_phase)
                PH_RESET, PH_WAKE: begin
                    // Everything here must be ignored
                    r   = ($urandom_range(0, 3) == 0);
                    sh  = ($urandom_range(0, 3) == 0);
                    ack = ($urandom_range(0, 3) == 0);
                    if ($urandom_range(0, 19) == 0) wake_lvl = ~wake_lvl;
                end
                PH_RUN: begin
                    ack = ($urandom_range(0, 3) == 0);
                    if ($urandom_range(0, 19) == 0) wake_lvl = ~wake_lvl;
                    if ($urandom_range(0, 11) == 0) begin
                        k  = $urandom_range(0, 2);
                        r  = (k != 1);
                        sh = (k != 0);
                        if (sh) begin
                            rst_at = -1;
                            case ($urandom_range(0, 4))
                                0: ack_at = 9;
                                1: ack_at = DT - 1;
                                2: ack_at = -1;
                                3: ack_at = $urandom_range(0, DT - 2);
                                default: begin ack_at = -1; rst_at = $urandom_range(0, DT - 2); end
                            endcase
                        end
                    end
                end
                PH_DRAIN: begin
                    r   = ($urandom_range(0, 2) == 0);
                    ack = (m_spent == ack_at);
                    rn  = !(m_spent == rst_at);
                end
                default: begin
                    if ($urandom_range(0, 9) == 0) wake_lvl = 1'b1;
                end
            endcase
            tick(r, sh, ack, wake_lvl, rn);
        end

        tick(1'b0, 1'b0, 1'b0, wake_lvl, 1'b1);
        @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
